param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram_if.sv | 24 ++
 rtl/param_ram.sv | 166 ++++++++++++++++
 tb/tb_param_ram.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_ram_if.sv
// Request/response bundle between requester channels and param_ram.
// Each multi-bit field carries channel c at bits [c*W +: W].
interface param_ram_if #(
    parameter int NCHAN  = 2,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic [NCHAN-1:0]        ram_read_req;
    logic [NCHAN-1:0]        ram_write_req;
    logic [NCHAN-1:0]        ram_done;
    logic [NCHAN*ADDR_W-1:0] ram_ma;
    logic [NCHAN*DATA_W-1:0] ram_in;
    logic [NCHAN*DATA_W-1:0] ram_out;

    modport master (
        output ram_read_req, ram_write_req, ram_ma, ram_in,
        input  ram_done, ram_out
    );

    modport slave (
        input  ram_read_req, ram_write_req, ram_ma, ram_in,
        output ram_done, ram_out
    );
endinterface

// File: rtl/param_ram.sv
// Multi-channel single-port RAM with round-robin arbitration and optional wait states.
// One access at a time: IDLE (grant) -> WAITING (WAIT cycles) -> DONE (one-cycle done pulse).
module param_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15,
    parameter int NCHAN  = 2,
    parameter int WAIT   = 0,
    parameter int DEBUG  = 0
) (
    input  logic        clk,
    input  logic        reset,
    param_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [DATA_W-1:0]       r_mem [DEPTH] = '{default: '0};
    logic [1:0]              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic [PTR_W-1:0]        r_grant;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_is_read;
    logic [NCHAN-1:0]        r_done;
    logic [NCHAN*DATA_W-1:0] r_out;

    logic                    w_any;
    logic [PTR_W-1:0]        w_sel;
    logic                    w_sel_rd;
    logic                    w_to_done;
    logic [PTR_W-1:0]        w_acc_chan;
    logic [ADDR_W-1:0]       w_acc_addr;
    logic [DATA_W-1:0]       w_acc_wdata;
    logic                    w_acc_rd;
    logic [DATA_W-1:0]       w_rdata;

    // Round-robin search for the first requesting channel starting at r_ptr.
    always_comb begin : arb
        logic [PTR_W:0] sum;
        w_any = 1'b0;
        w_sel = '0;
        sum   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NCHAN)) begin
                sum = sum - (PTR_W+1)'(NCHAN);
            end else begin
                sum = sum;
            end
            if (!w_any && (bus.ram_read_req[sum[PTR_W-1:0]] || bus.ram_write_req[sum[PTR_W-1:0]])) begin
                w_any = 1'b1;
                w_sel = sum[PTR_W-1:0];
            end else begin
                w_any = w_any;
            end
        end
        w_sel_rd = bus.ram_read_req[w_sel];
    end

    // Select the operands of the access completing at this edge; with no wait
    // states the grant and the completion share one edge, so live inputs are used.
    always_comb begin
        if (WAIT == 0) begin
            w_to_done   = (r_state == ST_IDLE) && w_any;
            w_acc_chan  = w_sel;
            w_acc_addr  = bus.ram_ma[w_sel*ADDR_W +: ADDR_W];
            w_acc_wdata = bus.ram_in[w_sel*DATA_W +: DATA_W];
            w_acc_rd    = w_sel_rd;
        end else begin
            w_to_done   = (r_state == ST_WAITING) && (r_cnt == CNT_W'(0));
            w_acc_chan  = r_grant;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_rd    = r_is_read;
        end
        w_rdata = r_mem[w_acc_addr];
    end

    // Memory array: written only on a live edge entering DONE, never cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && w_to_done && !w_acc_rd) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    // Access sequencer, arbitration pointer, done pulse and per-channel read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_read <= 1'b0;
            r_done    <= '0;
            r_out     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel;
                        r_addr    <= bus.ram_ma[w_sel*ADDR_W +: ADDR_W];
                        r_wdata   <= bus.ram_in[w_sel*DATA_W +: DATA_W];
                        r_is_read <= w_sel_rd;
                        if (w_sel == PTR_W'(NCHAN - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_sel + PTR_W'(1);
                        end
                        if (WAIT == 0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAITING;
                            r_cnt   <= CNT_W'((WAIT > 0) ? WAIT - 1 : 0);
                        end
                    end
                end
                ST_WAITING: begin
                    if (r_cnt == CNT_W'(0)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_to_done) begin
                r_done[w_acc_chan] <= 1'b1;
                if (w_acc_rd) begin
                    r_out[w_acc_chan*DATA_W +: DATA_W] <= w_rdata;
                end
            end
        end
    end

    assign bus.ram_done = r_done;
    assign bus.ram_out  = r_out;

    generate
        if (DEBUG != 0) begin : g_debug
            // Simulation trace of each completed access.
            always_ff @(posedge clk) begin
                if (reset && w_to_done) begin
                    if (w_acc_rd) begin
                        $display("ram: read [%o] -> %o", w_acc_addr, w_rdata);
                    end else begin
                        $display("ram: write [%o] <- %o", w_acc_addr, w_acc_wdata);
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench: u_a (2 channels, 2 wait states) and u_b (1 channel, no wait states).
module tb_param_ram;
    localparam int DW = 12;
    localparam int AW = 15;
    localparam int WA = 2;

    typedef struct {
        int              chan;
        bit              is_read;
        logic [DW-1:0]   data;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ptr_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [DW-1:0] mdl_a [2];
    logic [DW-1:0] mdl_b;

    param_ram_if #(.NCHAN(2), .ADDR_W(AW), .DATA_W(DW)) if_a ();
    param_ram_if #(.NCHAN(1), .ADDR_W(AW), .DATA_W(DW)) if_b ();

    param_ram #(.DATA_W(DW), .ADDR_W(AW), .NCHAN(2), .WAIT(WA), .DEBUG(0)) u_a (
        .clk(clk), .reset(rst_a), .bus(if_a.slave));
    param_ram #(.DATA_W(DW), .ADDR_W(AW), .NCHAN(1), .WAIT(0), .DEBUG(0)) u_b (
        .clk(clk), .reset(rst_b), .bus(if_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for u_a: pop one expectation per done pulse and compare.
    always @(negedge clk) begin : mon_a
        exp_t e;
        logic [1:0] m;
        if (rst_a !== 1'b1) begin
            mdl_a[0] = '0;
            mdl_a[1] = '0;
        end else if (if_a.ram_done !== 2'b00) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", 64'(if_a.ram_done), 64'd0);
            end else begin
                e = q_a.pop_front();
                m = 2'b00;
                m[e.chan] = 1'b1;
                check("a_done_chan", 64'(if_a.ram_done), 64'(m));
                check("a_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_read) mdl_a[e.chan] = e.data;
                check("a_ram_out", 64'(if_a.ram_out), 64'({mdl_a[1], mdl_a[0]}));
            end
        end
    end

    // Monitor for u_b.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_b !== 1'b1) begin
            mdl_b = '0;
        end else if (if_b.ram_done !== 1'b0) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done", 64'(if_b.ram_done), 64'd0);
            end else begin
                e = q_b.pop_front();
                check("b_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_read) mdl_b = e.data;
                check("b_ram_out", 64'(if_b.ram_out), 64'(mdl_b));
            end
        end
    end

    task automatic drive(input bit inst, input int ch, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!inst) begin
            if_a.ram_read_req[ch]     = rd;
            if_a.ram_write_req[ch]    = wr;
            if_a.ram_ma[ch*AW +: AW]  = a;
            if_a.ram_in[ch*DW +: DW]  = d;
        end else begin
            if_b.ram_read_req[0]  = rd;
            if_b.ram_write_req[0] = wr;
            if_b.ram_ma           = a;
            if_b.ram_in           = d;
        end
    endtask

    task automatic push(input bit inst, input exp_t e);
        if (!inst) q_a.push_back(e);
        else       q_b.push_back(e);
    endtask

    task automatic wait_done(input bit inst, input int ch);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = inst ? (if_b.ram_done[0] === 1'b1) : (if_a.ram_done[ch] === 1'b1);
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    // One access; with rd and wr both set, the read completes first and the write follows.
    task automatic acc(input bit inst, input int ch, input bit rd, input bit wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_d, input bit scr);
        exp_t e;
        int w;
        w = inst ? 0 : WA;
        @(negedge clk);
        drive(inst, ch, rd, wr, addr, wd);
        e.chan = ch; e.is_read = rd; e.data = exp_d; e.cyc = cyc + 1 + w;
        push(inst, e);
        if (!inst) ptr_a = (ch + 1) % 2;
        if (scr) begin
            @(posedge clk);
            #1;
            drive(inst, ch, rd, wr, addr ^ 15'd1, ~wd);
        end
        wait_done(inst, ch);
        if (rd && wr) begin
            drive(inst, ch, 1'b0, 1'b1, addr, wd);
            e.is_read = 1'b0; e.cyc = cyc + 2 + w;
            push(inst, e);
            wait_done(inst, ch);
        end
        drive(inst, ch, 1'b0, 1'b0, addr, wd);
    endtask

    // Both u_a channels read at once; each drops its request on its own done.
    task automatic dual(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        int first;
        int c0;
        bit [1:0] pend;
        @(negedge clk);
        drive(1'b0, 0, 1'b1, 1'b0, a0, 12'd0);
        drive(1'b0, 1, 1'b1, 1'b0, a1, 12'd0);
        first = ptr_a;
        c0 = cyc;
        e.is_read = 1'b1;
        e.chan = first;     e.data = first ? d1 : d0; e.cyc = c0 + 1 + WA;     push(1'b0, e);
        e.chan = 1 - first; e.data = first ? d0 : d1; e.cyc = c0 + 3 + 2 * WA; push(1'b0, e);
        pend = 2'b11;
        for (int k = 0; k < 60 && pend != 2'b00; k++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (pend[c] && if_a.ram_done[c] === 1'b1) begin
                    drive(1'b0, c, 1'b0, 1'b0, c ? a1 : a0, 12'd0);
                    pend[c] = 1'b0;
                end
            end
        end
        if (pend != 2'b00) check("dual_timeout", 64'(pend), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.ram_read_req = '0; if_a.ram_write_req = '0; if_a.ram_ma = '0; if_a.ram_in = '0;
        if_b.ram_read_req = '0; if_b.ram_write_req = '0; if_b.ram_ma = '0; if_b.ram_in = '0;
        repeat (3) @(negedge clk);
        check("reset_a_out", 64'(if_a.ram_out), 64'd0);
        check("reset_a_done", 64'(if_a.ram_done), 64'd0);
        check("reset_b_out", 64'(if_b.ram_out), 64'd0);
        check("reset_b_done", 64'(if_b.ram_done), 64'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Single channel, no wait states
        acc(1'b1, 0, 1'b0, 1'b1, 15'o00017, 12'o1234, 12'o0000, 1'b0);
        acc(1'b1, 0, 1'b1, 1'b0, 15'o00017, 12'o0000, 12'o1234, 1'b0);
        acc(1'b1, 0, 1'b0, 1'b1, 15'o77777, 12'o7070, 12'o0000, 1'b0);
        acc(1'b1, 0, 1'b1, 1'b0, 15'o00000, 12'o0000, 12'o0000, 1'b0);
        acc(1'b1, 0, 1'b1, 1'b0, 15'o77777, 12'o0000, 12'o7070, 1'b0);

        // Two channels, two wait states; address is scrambled mid-access on one read
        acc(1'b0, 0, 1'b0, 1'b1, 15'o00017, 12'o1234, 12'o0000, 1'b0);
        acc(1'b0, 1, 1'b0, 1'b1, 15'o00020, 12'o4321, 12'o0000, 1'b0);
        acc(1'b0, 0, 1'b1, 1'b0, 15'o00017, 12'o0000, 12'o1234, 1'b1);
        acc(1'b0, 1, 1'b1, 1'b0, 15'o00020, 12'o0000, 12'o4321, 1'b0);

        // Boundary addresses
        acc(1'b0, 0, 1'b0, 1'b1, 15'o00000, 12'o1111, 12'o0000, 1'b0);
        acc(1'b0, 1, 1'b0, 1'b1, 15'o77777, 12'o6543, 12'o0000, 1'b0);
        acc(1'b0, 1, 1'b1, 1'b0, 15'o00000, 12'o0000, 12'o1111, 1'b0);
        acc(1'b0, 0, 1'b1, 1'b0, 15'o77777, 12'o0000, 12'o6543, 1'b0);

        // Read wins over a simultaneous write; the write follows
        acc(1'b0, 1, 1'b0, 1'b1, 15'o00005, 12'o0007, 12'o0000, 1'b0);
        acc(1'b0, 0, 1'b1, 1'b1, 15'o00005, 12'o0077, 12'o0007, 1'b0);
        acc(1'b0, 1, 1'b1, 1'b0, 15'o00005, 12'o0000, 12'o0077, 1'b0);

        // Contending channels alternate
        dual(15'o00017, 15'o00020, 12'o1234, 12'o4321);
        dual(15'o77777, 15'o00000, 12'o6543, 12'o1111);

        // Reset during WAITING aborts a write
        acc(1'b0, 0, 1'b0, 1'b1, 15'o00100, 12'o0321, 12'o0000, 1'b0);
        acc(1'b0, 0, 1'b1, 1'b0, 15'o00100, 12'o0000, 12'o0321, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b1, 15'o00100, 12'o0555);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("abort_out_zero", 64'(if_a.ram_out), 64'd0);
        check("abort_done_zero", 64'(if_a.ram_done), 64'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 15'o00100, 12'o0000);
        ptr_a = 0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        acc(1'b0, 1, 1'b1, 1'b0, 15'o00100, 12'o0000, 12'o0321, 1'b0);

        repeat (6) @(negedge clk);
        check("a_pending_empty", 64'(q_a.size()), 64'd0);
        check("b_pending_empty", 64'(q_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
